// File: rtl/pc_sequencer_pkg.sv
// Shared MIPS fetch constants: sequencer state encoding, reset vector
// default and instruction-format widths.
package pc_sequencer_pkg;

  // RUN advances or redirects the PC; HOLD parks a captured redirect
  // until the stall releases.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0040_0000;
  localparam int unsigned INSTR_BYTES          = 4;
  localparam int unsigned JUMP_INDEX_W         = 26;

endpackage

// File: rtl/pc_target_select.sv
// Combinational redirect target computation and request priority.
// jr beats jump beats branch; losing requests are simply dropped.
module pc_target_select
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    branch_i,
  input  logic [WIDTH-1:0]        branch_base_i,
  input  logic [WIDTH-1:0]        branch_offset_sl2_i,
  input  logic                    jump_i,
  input  logic [JUMP_INDEX_W-1:0] jump_index_i,
  input  logic                    jr_i,
  input  logic [WIDTH-1:0]        jr_target_i,
  output logic                    request,
  output logic [WIDTH-1:0]        target,
  output logic                    jr_misaligned
);

  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] jr_aligned;

  // Jump keeps the 256 MB region of the delay-slot PC; jr drops the low
  // two bits so fetch stays word aligned even on a bad register value.
  assign branch_target = branch_base_i + branch_offset_sl2_i;
  assign jump_target   = {branch_base_i[WIDTH-1:28], jump_index_i, 2'b00};
  assign jr_aligned    = {jr_target_i[WIDTH-1:2], 2'b00};

  // Priority mux over the three redirect sources.
  always_comb begin
    request       = 1'b0;
    target        = '0;
    jr_misaligned = 1'b0;
    if (jr_i) begin
      request       = 1'b1;
      target        = jr_aligned;
      jr_misaligned = |jr_target_i[1:0];
    end else if (jump_i) begin
      request = 1'b1;
      target  = jump_target;
    end else if (branch_i) begin
      request = 1'b1;
      target  = branch_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer. Valid/ready-free: a request is sampled every cycle
// the sequencer is in RUN; while stalled the first accepted redirect is
// parked and every later request is ignored until the stall releases.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    branch_i,
  input  logic [WIDTH-1:0]        branch_base_i,
  input  logic [WIDTH-1:0]        branch_offset_sl2_i,
  input  logic                    jump_i,
  input  logic [JUMP_INDEX_W-1:0] jump_index_i,
  input  logic                    jr_i,
  input  logic [WIDTH-1:0]        jr_target_i,
  output logic [WIDTH-1:0]        pc_o,
  output logic [WIDTH-1:0]        pc_plus4_o,
  output logic                    redirect_o,
  output logic                    pending_o,
  output logic                    misaligned_o
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             redirect_q, redirect_d;
  logic             misaligned;

  logic             request;
  logic [WIDTH-1:0] target;
  logic             jr_misaligned;

  pc_target_select #(
    .WIDTH(WIDTH)
  ) u_target_select (
    .branch_i           (branch_i),
    .branch_base_i      (branch_base_i),
    .branch_offset_sl2_i(branch_offset_sl2_i),
    .jump_i             (jump_i),
    .jump_index_i       (jump_index_i),
    .jr_i               (jr_i),
    .jr_target_i        (jr_target_i),
    .request            (request),
    .target             (target),
    .jr_misaligned      (jr_misaligned)
  );

  // Sequential wrap at the top of the address space is natural modulo
  // arithmetic.
  assign pc_plus4_o = pc_q + WIDTH'(INSTR_BYTES);
  assign pc_o       = pc_q;
  assign redirect_o = redirect_q;
  assign pending_o  = (state_q == ST_HOLD);
  // Gated by reset so the flag is quiet while reset is held, even though
  // the state register already reads RUN.
  assign misaligned_o = misaligned & ~reset;

  // State, PC, parked target and redirect pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      pending_q  <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      redirect_q <= redirect_d;
    end
  end

  // Next-state, next-PC and accept-cycle flag decode.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    redirect_d = 1'b0;
    misaligned = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (request) begin
          misaligned = jr_misaligned;
        end
        if (!stall_i) begin
          if (request) begin
            pc_d       = target;
            redirect_d = 1'b1;
          end else begin
            pc_d = pc_plus4_o;
          end
        end else if (request) begin
          pending_d = target;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!stall_i) begin
          pc_d       = pending_q;
          redirect_d = 1'b1;
          pending_d  = '0;
          state_d    = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with an expected-result queue.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_base_i;
  logic [31:0] branch_offset_sl2_i;
  logic        jump_i;
  logic [25:0] jump_index_i;
  logic        jr_i;
  logic [31:0] jr_target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_o;
  logic        pending_o;
  logic        misaligned_o;

  int checks   = 0;
  int failures = 0;

  // {pc, redirect, pending} expected after the next rising edge
  logic [33:0] exp_q[$];

  pc_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .stall_i            (stall_i),
    .branch_i           (branch_i),
    .branch_base_i      (branch_base_i),
    .branch_offset_sl2_i(branch_offset_sl2_i),
    .jump_i             (jump_i),
    .jump_index_i       (jump_index_i),
    .jr_i               (jr_i),
    .jr_target_i        (jr_target_i),
    .pc_o               (pc_o),
    .pc_plus4_o         (pc_plus4_o),
    .redirect_o         (redirect_o),
    .pending_o          (pending_o),
    .misaligned_o       (misaligned_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    stall_i             = 1'b0;
    branch_i            = 1'b0;
    branch_base_i       = 32'h0;
    branch_offset_sl2_i = 32'h0;
    jump_i              = 1'b0;
    jump_index_i        = 26'h0;
    jr_i                = 1'b0;
    jr_target_i         = 32'h0;
  endtask

  // Driver: present one cycle of stimulus, check the accept-cycle flag,
  // queue the post-edge expectation, then clock and score it.
  task automatic step(input string tag,
                      input logic st, input logic br, input logic jp, input logic jq,
                      input logic [31:0] base, input logic [31:0] off,
                      input logic [25:0] idx, input logic [31:0] jt,
                      input logic exp_mis,
                      input logic [31:0] exp_pc, input logic exp_red, input logic exp_pend);
    logic [33:0] e;
    stall_i             = st;
    branch_i            = br;
    jump_i              = jp;
    jr_i                = jq;
    branch_base_i       = base;
    branch_offset_sl2_i = off;
    jump_index_i        = idx;
    jr_target_i         = jt;
    #1;
    check({tag, ".misaligned"}, {31'h0, misaligned_o}, {31'h0, exp_mis});
    exp_q.push_back({exp_pc, exp_red, exp_pend});
    @(posedge clk);
    #1;
    idle_inputs();
    e = exp_q.pop_front();
    check({tag, ".pc"},       pc_o,                   e[33:2]);
    check({tag, ".pc_plus4"}, pc_plus4_o,             e[33:2] + 32'd4);
    check({tag, ".redirect"}, {31'h0, redirect_o},    {31'h0, e[1]});
    check({tag, ".pending"},  {31'h0, pending_o},     {31'h0, e[0]});
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #2;
    check("reset.pc",         pc_o,                  32'h0040_0000);
    check("reset.redirect",   {31'h0, redirect_o},   32'h0);
    check("reset.pending",    {31'h0, pending_o},    32'h0);
    check("reset.misaligned", {31'h0, misaligned_o}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Free-running sequential fetch
    step("free1", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0040_0004, 0, 0);
    step("free2", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0040_0008, 0, 0);
    step("free3", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0040_000C, 0, 0);

    // Backward taken branch
    step("branch", 0, 1, 0, 0, 32'h0040_0010, 32'hFFFF_FFF0, 26'h0, 32'h0, 0, 32'h0040_0000, 1, 0);
    step("after_branch", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0040_0004, 0, 0);

    // Jump beats branch
    step("jump_vs_branch", 0, 1, 1, 0, 32'h0040_0010, 32'h0000_0020, 26'h0000100, 32'h0, 0, 32'h0000_0400, 1, 0);
    step("after_jump", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_0404, 0, 0);

    // Stall with no request holds
    step("stall_idle", 1, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_0404, 0, 0);

    // Stalled misaligned jr is parked; later requests lose
    step("hold_capture", 1, 0, 0, 1, 32'h0, 32'h0, 26'h0, 32'h0040_0102, 1, 32'h0000_0404, 0, 1);
    step("hold_wait", 1, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_0404, 0, 1);
    step("hold_ignore", 1, 1, 0, 1, 32'h0050_0000, 32'h0000_0040, 26'h0, 32'h0060_0001, 0, 32'h0000_0404, 0, 1);
    step("hold_release", 0, 1, 0, 0, 32'h0050_0000, 32'h0000_0040, 26'h0, 32'h0, 0, 32'h0040_0100, 1, 0);
    step("after_release", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0040_0104, 0, 0);

    // jr beats jump and branch; misaligned flag on immediate apply
    step("jr_priority", 0, 1, 1, 1, 32'h0040_0010, 32'h0000_0020, 26'h0000100, 32'h0040_0203, 1, 32'h0040_0200, 1, 0);

    // Wrap at the top of the address space
    step("to_top", 0, 0, 0, 1, 32'h0, 32'h0, 26'h0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0);
    step("wrap", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_0000, 0, 0);
    step("after_wrap", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0000_0004, 0, 0);

    // Reset in the middle of HOLD, away from the clock edge
    step("pre_reset_hold", 1, 0, 0, 1, 32'h0, 32'h0, 26'h0, 32'h0050_0000, 0, 32'h0000_0004, 0, 1);
    stall_i = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("midreset.pc",       pc_o,                  32'h0040_0000);
    check("midreset.pending",  {31'h0, pending_o},    32'h0);
    check("midreset.redirect", {31'h0, redirect_o},   32'h0);
    @(posedge clk);
    #1;
    stall_i = 1'b0;
    reset   = 1'b0;
    step("post_reset1", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0040_0004, 0, 0);
    step("post_reset2", 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, 0, 32'h0040_0008, 0, 0);

    // Random unstalled branches against a bench-side adder
    for (int i = 0; i < 8; i++) begin
      logic [31:0] b;
      logic [31:0] o;
      b = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      o = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      step("rand_branch", 0, 1, 0, 0, b, o, 26'h0, 32'h0, 0, b + o, 1, 0);
    end

    check("queue_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0040_0000, shall be the PC value loaded on reset.
REQ-002 Parameter WIDTH, default 32, shall be the PC and target datapath width.
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  shall be the asynchronous, active-high reset.
REQ-005 stall_i  input  1  shall mean hold PC; no advance, no redirect applied.
REQ-006 branch_i  input  1  shall mean conditional branch resolved taken.
REQ-007 branch_base_i  input  32  shall be PC+4 of the branch instruction.
REQ-008 branch_offset_sl2_i  input  32  shall be the sign-extended offset already shifted left by 2 upstream.
REQ-009 jump_i  input  1  shall mean J/JAL request.
REQ-010 jump_index_i  input  26  shall be the instruction index field.
REQ-011 jr_i  input  1  shall mean JR/JALR request.
REQ-012 jr_target_i  input  32  shall be the register-sourced target.
REQ-013 pc_o  output  32  shall be the current fetch address.
REQ-014 pc_plus4_o  output  32  shall be pc_o+4, combinational.
REQ-015 redirect_o  output  1  shall pulse high for the cycle in which a redirect target is loaded into pc_o.
REQ-016 pending_o  output  1  shall be high while a captured redirect awaits stall release.
REQ-017 misaligned_o  output  1  shall pulse high for one cycle when an accepted jr target has bits[1:0] != 0.

Function
REQ-018 Targets: branch = branch_base_i + branch_offset_sl2_i, mod 2^32; jump = {branch_base_i[31:28], jump_index_i, 2'b00}; jr = {jr_target_i[31:2], 2'b00}.
REQ-019 Priority when multiple requests are asserted in one cycle: jr_i > jump_i > branch_i; lower requests are discarded.
REQ-020 States: RUN, HOLD.
REQ-021 RUN, stall_i=0, no request: pc_o <= pc_o+4 next edge; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 RUN, stall_i=0, request: pc_o <= selected target next edge; redirect_o=1 that following cycle; state stays RUN.
REQ-023 RUN, stall_i=1, no request: pc_o holds.
REQ-024 RUN, stall_i=1, request: target captured into pending register; pc_o holds; next state HOLD.
REQ-025 HOLD, stall_i=1: pc_o and pending target hold; new requests are ignored, so the oldest redirect wins.
REQ-026 HOLD, stall_i=0: pc_o <= pending target next edge; redirect_o=1 that following cycle; pending cleared; next state RUN; any request in that cycle is ignored.
REQ-027 pending_o shall equal (state == HOLD).
REQ-028 misaligned_o shall assert in the cycle the jr target is accepted, whether applied immediately or captured.
REQ-029 Latency: an unstalled request shall produce the target on pc_o exactly one cycle later.

Reset
REQ-030 Reset asserted shall immediately force pc_o=RESET_VECTOR, state RUN, pending target 0, redirect_o=0, misaligned_o=0, independent of clk.
REQ-031 Reset during HOLD shall discard the pending redirect.
REQ-032 On the first edge after reset deasserts, normal RUN behaviour shall apply.

Structure
REQ-033 State encoding, RESET_VECTOR default and instruction-width constants shall live in the shared MIPS package.
REQ-034 One sub-module, pc_target_select, shall implement the combinational REQ-018/019 target computation and priority; the state machine and registers shall live in pc_sequencer.

Verification
REQ-035 Reset, then 3 free cycles -> pc_o = 0x00400000, 0x00400004, 0x00400008, 0x0040000C.
REQ-036 branch_i=1, base=0x00400010, offset=0xFFFFFFF0, unstalled -> next pc_o=0x00400000, redirect_o=1 for one cycle.
REQ-037 jump_i=1 and branch_i=1 simultaneously, base=0x00400010, index=0x0000100 -> pc_o=0x00000400; branch discarded.
REQ-038 stall_i=1 with jr_i=1, target=0x00400102 -> misaligned_o pulses, pending_o=1; a branch request 2 cycles later is ignored; on release pc_o=0x00400100, redirect_o pulse.
REQ-039 pc_o=0xFFFFFFFC, no request -> pc_o=0x00000000.
REQ-040 Reset asserted mid-HOLD, off-edge -> pc_o=0x00400000 and pending_o=0 immediately; no redirect after release.
